// File: rtl/sync_debounce_if.sv
// Conditioner bus: raw inputs and sample qualifier in, clean levels and pulses out.
// The fall pulse exists only when FALL_PULSE_EN is defined.
interface sync_debounce_if #(
  parameter int WIDTH = 4
);
  logic             sample_en;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rise;
`ifdef FALL_PULSE_EN
  logic [WIDTH-1:0] fall;
`endif

  modport master (
    output sample_en,
    output din,
    input  q,
    input  rise
`ifdef FALL_PULSE_EN
    , input fall
`endif
  );

  modport slave (
    input  sample_en,
    input  din,
    output q,
    output rise
`ifdef FALL_PULSE_EN
    , output fall
`endif
  );
endinterface

// File: rtl/sync_debounce.sv
// Per-channel synchroniser, qualified debounce counter and registered edge pulses.
// Optional feature: FALL_PULSE_EN adds a registered 1->0 pulse output.
module sync_debounce #(
  parameter int WIDTH    = 4,
  parameter int STAGES   = 2,
  parameter int CNT_W    = 16,
  parameter int DB_COUNT = 50000
) (
  input  logic            s_clk,
  input  logic            s_rst,
  sync_debounce_if.slave  db
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_debounce: STAGES must be 2 or more");
  end
  if (DB_COUNT < 1) begin : g_bad_count_lo
    $error("sync_debounce: DB_COUNT must be at least 1");
  end
  if (longint'(DB_COUNT) >= (longint'(1) << CNT_W)) begin : g_bad_count_hi
    $error("sync_debounce: DB_COUNT does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0][CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0]  cnt_d;
  logic [WIDTH-1:0]             q_q;
  logic [WIDTH-1:0]             q_d;
  logic [WIDTH-1:0]             rise_q;
  logic [WIDTH-1:0]             rise_d;
  logic [WIDTH-1:0]             s;

  assign s = sync_q[STAGES-1];

  // A match between s and q discards any partial count.
  always_comb begin
    cnt_d = cnt_q;
    q_d   = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == q_q[i]) begin
        cnt_d[i] = '0;
      end else if (db.sample_en) begin
        if (cnt_q[i] == DB_LAST) begin
          q_d[i]   = s[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  assign rise_d = q_d & ~q_q;

  always_ff @(posedge s_clk) begin
    if (!s_rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      q_q    <= '0;
      rise_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], db.din};
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      rise_q <= rise_d;
    end
  end

  assign db.q    = q_q;
  assign db.rise = rise_q;

`ifdef FALL_PULSE_EN
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;

  assign fall_d = q_q & ~q_d;

  always_ff @(posedge s_clk) begin
    if (!s_rst) begin
      fall_q <= '0;
    end else begin
      fall_q <= fall_d;
    end
  end

  assign db.fall = fall_q;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: per-cycle vector table plus
// hand-written gated-sample and reset corner sequences.
module tb_sync_debounce;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  sync_debounce_if #(.WIDTH(2)) bus ();

  sync_debounce #(
    .WIDTH   (2),
    .STAGES  (2),
    .CNT_W   (3),
    .DB_COUNT(4)
  ) dut (
    .s_clk(clk),
    .s_rst(rst_n),
    .db   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] din;
    logic [1:0] q;
    logic [1:0] rise;
    logic [1:0] fall;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [1:0] d,
                     input logic [1:0] eq, input logic [1:0] er,
                     input logic [1:0] ef);
    vec_t v;
    v.rst  = r;
    v.en   = e;
    v.din  = d;
    v.q    = eq;
    v.rise = er;
    v.fall = ef;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] d);
    rst_n         = r;
    bus.sample_en = e;
    bus.din       = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int           samples;
    logic         en;
    logic         fire;
    logic [1:0]   eq;
    logic [1:0]   er;

    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.sample_en = 1'b0;
    bus.din       = 2'b00;

    // reset, then 3-cycle glitch on ch0
    repeat (2) add(0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (3) add(1, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    repeat (5) add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    // 4-cycle pulse reaches q at E0+5, then falls at E0'+5
    repeat (4) add(1, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b01, 2'b01, 2'b00);
    repeat (3) add(1, 1, 2'b00, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b00, 2'b00, 2'b01);
    add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    // independence: ch1 bounces while ch0 steps high
    add(1, 1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 2'b01, 2'b01, 2'b00);
    repeat (2) add(1, 1, 2'b01, 2'b01, 2'b00, 2'b00);
    // reset held 5 cycles with din=11
    repeat (5) add(0, 1, 2'b11, 2'b00, 2'b00, 2'b00);
    repeat (5) add(1, 1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b11, 2'b11, 2'b11, 2'b00);
    add(1, 1, 2'b11, 2'b11, 2'b00, 2'b00);
    // ch0 falls
    repeat (5) add(1, 1, 2'b10, 2'b11, 2'b00, 2'b00);
    add(1, 1, 2'b10, 2'b10, 2'b00, 2'b01);
    add(1, 1, 2'b10, 2'b10, 2'b00, 2'b00);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].din);
      check("vec_q", i, bus.q, vecs[i].q);
      check("vec_rise", i, bus.rise, vecs[i].rise);
`ifdef FALL_PULSE_EN
      check("vec_fall", i, bus.fall, vecs[i].fall);
      check("vec_rise_fall_excl", i, bus.rise & bus.fall, 2'b00);
`endif
    end

    // gated sample_en: one in four, with a long frozen stretch
    step(0, 0, 2'b00);
    step(0, 0, 2'b00);
    check("gate_reset_q", 0, bus.q, 2'b00);
    step(1, 0, 2'b10);
    step(1, 0, 2'b10);
    check("gate_prop_q", 0, bus.q, 2'b00);
    samples = 0;
    for (int k = 0; k < 32; k++) begin
      en   = (k % 4 == 3) && !(k >= 8 && k < 20);
      fire = en && (samples == 3);
      if (en) samples++;
      step(1, en, 2'b10);
      eq = (samples >= 4) ? 2'b10 : 2'b00;
      er = fire ? 2'b10 : 2'b00;
      check("gate_q", k, bus.q, eq);
      check("gate_rise", k, bus.rise, er);
    end

    // reset mid-count after two counted samples
    step(0, 1, 2'b00);
    repeat (4) step(1, 1, 2'b01);
    check("mid_pre_q", 0, bus.q, 2'b00);
    step(0, 1, 2'b01);
    check("mid_rst_q", 0, bus.q, 2'b00);
    for (int k = 0; k < 7; k++) begin
      step(1, 1, 2'b01);
      check("mid_q", k, bus.q, (k >= 5) ? 2'b01 : 2'b00);
      check("mid_rise", k, bus.rise, (k == 5) ? 2'b01 : 2'b00);
    end

    // reset on the edge that would complete the count
    step(0, 1, 2'b00);
    repeat (5) step(1, 1, 2'b01);
    check("same_pre_q", 0, bus.q, 2'b00);
    step(0, 1, 2'b01);
    check("same_q", 0, bus.q, 2'b00);
    check("same_rise", 0, bus.rise, 2'b00);
    step(1, 1, 2'b01);
    check("same_after_q", 0, bus.q, 2'b00);
    check("same_after_rise", 0, bus.rise, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sync_debounce.md
# sync_debounce

Parametrised, multi-channel input conditioner for the stopwatch push-buttons and switches. It generalises our single-bit synchronous-reset flip-flop into three stages per channel: an N-stage synchroniser, a debounce counter with a qualified sample tick, and a registered edge detector. It sits between the board pins and the stopwatch control FSM, so that logic only ever sees clean levels and one-cycle press pulses.

## Interface
- WIDTH, 4: number of independent channels.
- STAGES, 2: synchroniser flops per channel; legal range is 2 or more.
- CNT_W, 16: debounce counter width.
- DB_COUNT, 50000: consecutive qualified samples of a changed level required before the output follows; legal range is 1 to 2^CNT_W-1.

- s_clk  in  1  system clock; every flop is clocked on the rising edge.
- s_rst  in  1  reset, synchronous, active-low; clock s_clk.
- sample_en  in  1  debounce sample qualifier. It is tied high to sample every cycle, or driven by a slow tick.
- din  in  WIDTH  raw asynchronous inputs.
- q  out  WIDTH  debounced level, registered.
- rise  out  WIDTH  one-cycle pulse on a 0→1 change of q, registered.
- fall  out  WIDTH  one-cycle pulse on a 1→0 change of q. Present only with FALL_PULSE_EN (see Configuration).

## Operation
- Reset: when s_rst=0 at a clock edge, the following all clear to 0: sync stages, counters, q, rise, fall. Reset overrides sample_en and din.
- Each channel is fully independent; no state is shared between channels.
- Synchroniser: din[i] is shifted through STAGES flops. Let s[i] denote the last stage.
- Debounce, evaluated per edge for each channel:
  - If s[i]==q[i]: cnt[i] is set to 0.
  - Else if sample_en=0: cnt[i] holds.
  - Else if cnt[i]+1==DB_COUNT: q[i] is set to s[i] and cnt[i] is set to 0.
  - Else: cnt[i] increments by 1.
- Any cycle in which s matches q again discards the partial count. Glitches shorter than DB_COUNT qualified samples therefore never reach q.
- The counter never exceeds DB_COUNT-1, so it cannot wrap.
- rise[i] is registered in the same edge as the 0→1 update of q[i]. It is high for exactly one cycle, then returns to 0 on the next edge.
- Out-of-range parameter values (STAGES<2, DB_COUNT=0, or DB_COUNT≥2^CNT_W) must raise an elaboration or simulation error.

## Timing
- With sample_en=1: if din[i] changes before edge E0 and stays stable, q[i] and rise[i] update at edge E0+STAGES+DB_COUNT-1.
- With a gated sample_en: q updates on the edge carrying the DB_COUNT-th sample_en that occurs while s≠q.
- If reset and a count completion occur on the same edge, reset wins: q stays 0 and no pulse is produced.
- Reset mid-count discards all history. After reset is released, a full STAGES+DB_COUNT-1 latency applies again.

## Configuration
- FALL_PULSE_EN defined:
  - The fall port exists.
  - fall[i] is registered high for one cycle in the same edge as a 1→0 update of q[i].
  - rise and fall are never high together on the same channel.
- FALL_PULSE_EN undefined:
  - The fall port and its flops are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=2, STAGES=2, DB_COUNT=4, CNT_W=3.
- Reset: hold s_rst=0 for 5 cycles with din=2'b11, then release. q stays 2'b00 throughout reset. At the 5th edge after release, q=2'b11 and rise=2'b11 for one cycle, then rise=2'b00.
- Glitch: din[0] high for 3 cycles, then low, with sample_en=1. Required: q[0]=0 and rise[0]=0 throughout. A 4-cycle pulse instead must give q[0]=1 at E0+5.
- Gated sample: sample_en high one cycle in every four; din[1] steps 0→1. q[1] must rise on the edge carrying the 4th sample_en after s[1]=1, not before. Holding sample_en=0 freezes the count.
- Reset mid-count: din[0]=1, assert s_rst=0 for one cycle after 2 counted samples, then release. Required: q[0]=1 at exactly 5 edges after release, with no early pulse.
- Independence: din[0] rises while din[1] simultaneously bounces 1-0-1-0 over 4 cycles. Required: q=2'b01 and rise=2'b01 once; channel 1 stays 0.
- Fall pulse (FALL_PULSE_EN defined): with q[0]=1, drive din[0]=0. Required: fall[0]=1 for one cycle at E0+5, rise[0]=0, q[0]=0. With the macro undefined, the fall port must be absent and there must be no lint error.
